ctrl_pipe_stages: RTL and testbench

- Parametrised carrier for decoded control bundles through the back-end pipeline stages (E/M/W by default).
- Generalises the fixed three-register control pipeline: configurable bundle width and stage count, per-stage stall and flush, a configurable exception-kill mask, and per-stage valid bits.
- Adds a registered occupancy count and per-source forwarding/hazard match vectors, so hazard logic queries one block instead of tapping individual stage flops.

---
 rtl/ctrl_pipe_pkg.sv | 22 ++
 rtl/ctrl_pipe_reg.sv | 62 ++++++
 rtl/ctrl_pipe_stages.sv | 149 ++++++++++++++
 tb/tb_ctrl_pipe_stages.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared constants for the back-end control pipeline.
// Holds the bit positions of each control signal inside the decoded bundle
// and the default bundle width. It declares no ports; modules import it.
package ctrl_pipe_pkg;

    localparam int CTRL_JUMP      = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUSRCB   = 4;
    localparam int CTRL_REGDST    = 5;
    localparam int CTRL_REGWRITE  = 6;
    localparam int CTRL_ALUSRCA   = 7;
    localparam int CTRL_JAL       = 8;
    localparam int CTRL_JR        = 9;
    localparam int CTRL_BAL       = 10;
    localparam int CTRL_HILOWRITE = 11;
    localparam int CTRL_CP0WRITE  = 12;

    localparam int CTRL_W = 13;

endpackage

// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: one pipeline stage register holding {valid, ctrl, dst}.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   clr               clear the stage at the edge (wins over load)
//   load              capture d_* at the edge; otherwise hold
//   d_valid/d_ctrl/d_dst   incoming entry
//   q_valid/q_ctrl/q_dst   stored entry
// An entry loaded with d_valid=0 is stored as an all-zero bubble, so an
// invalid stage never carries stale ctrl or dst bits.
module ctrl_pipe_reg #(
    parameter int CTRL_W = ctrl_pipe_pkg::CTRL_W,
    parameter int DST_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DST_W-1:0]  d_dst,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DST_W-1:0]  q_dst
);
    import ctrl_pipe_pkg::*;

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DST_W-1:0]  dst_q, dst_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        dst_d   = dst_q;
        if (clr) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            dst_d   = '0;
        end else if (load) begin
            valid_d = d_valid;
            ctrl_d  = d_valid ? d_ctrl : '0;
            dst_d   = d_valid ? d_dst  : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            dst_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dst_q   <= dst_d;
        end
    end

    assign q_valid = valid_q;
    assign q_ctrl  = ctrl_q;
    assign q_dst   = dst_q;

endmodule

// File: rtl/ctrl_pipe_stages.sv
// ctrl_pipe_stages: carries decoded control bundles through the back-end
// stages (stage 0 = E ... stage STAGES-1 = W) with per-stage stall/flush,
// exception kill, occupancy count and forwarding match vectors.
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   in_valid/in_ctrl/in_dst    instruction from decode
//   in_ready                   stage 0 loads this cycle
//   stall, flush               per-stage hold / clear requests
//   except                     clears the stages selected by EXC_MASK
//   src_a, src_b               source registers queried for forwarding
//   stage_valid/ctrl/dst       per-stage contents, stage k at slot k
//   occ                        registered count of valid stages
//   fwd_x_hit, fwd_x_pri       per-stage match, and youngest match one-hot
module ctrl_pipe_stages #(
    parameter int                CTRL_W   = ctrl_pipe_pkg::CTRL_W,
    parameter int                STAGES   = 3,
    parameter int                DST_W    = 5,
    parameter int                REGW_BIT = ctrl_pipe_pkg::CTRL_REGWRITE,
    parameter logic [STAGES-1:0] EXC_MASK = {STAGES{1'b1}},
    parameter int                CNT_W    = $clog2(STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [DST_W-1:0]           in_dst,
    output logic                       in_ready,
    input  logic [STAGES-1:0]          stall,
    input  logic [STAGES-1:0]          flush,
    input  logic                       except,
    input  logic [DST_W-1:0]           src_a,
    input  logic [DST_W-1:0]           src_b,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*CTRL_W-1:0]   stage_ctrl,
    output logic [STAGES*DST_W-1:0]    stage_dst,
    output logic [CNT_W-1:0]           occ,
    output logic [STAGES-1:0]          fwd_a_hit,
    output logic [STAGES-1:0]          fwd_b_hit,
    output logic [STAGES-1:0]          fwd_a_pri,
    output logic [STAGES-1:0]          fwd_b_pri
);
    import ctrl_pipe_pkg::*;

    logic [STAGES-1:0] hold, kill, load, valid_nxt;
    logic [STAGES-1:0] st_valid, src_valid;
    logic [CTRL_W-1:0] st_ctrl [STAGES];
    logic [CTRL_W-1:0] src_ctrl [STAGES];
    logic [DST_W-1:0]  st_dst [STAGES];
    logic [DST_W-1:0]  src_dst [STAGES];
    logic [CNT_W-1:0]  occ_q, occ_d;

    function automatic logic [CNT_W-1:0] popcount(input logic [STAGES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < STAGES; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [STAGES-1:0] lowest_bit(input logic [STAGES-1:0] v);
        logic [STAGES-1:0] r;
        logic              found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // A stall anywhere downstream backs up every younger stage.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) hold[k] = hold[k+1] | stall[k];
        kill = flush | ({STAGES{except}} & EXC_MASK);
        load = ~hold;
    end

    assign in_ready = ~hold[0];

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign src_valid[g] = in_valid;
                assign src_ctrl[g]  = in_ctrl;
                assign src_dst[g]   = in_dst;
            end else begin : g_body
                // A held upstream stage keeps its entry, so this stage takes a bubble.
                assign src_valid[g] = st_valid[g-1] & ~hold[g-1];
                assign src_ctrl[g]  = st_ctrl[g-1];
                assign src_dst[g]   = st_dst[g-1];
            end

            ctrl_pipe_reg #(
                .CTRL_W (CTRL_W),
                .DST_W  (DST_W)
            ) u_reg (
                .clk     (clk),
                .rst     (rst),
                .clr     (kill[g]),
                .load    (load[g]),
                .d_valid (src_valid[g]),
                .d_ctrl  (src_ctrl[g]),
                .d_dst   (src_dst[g]),
                .q_valid (st_valid[g]),
                .q_ctrl  (st_ctrl[g]),
                .q_dst   (st_dst[g])
            );

            assign stage_valid[g]                 = st_valid[g];
            assign stage_ctrl[g*CTRL_W +: CTRL_W] = st_ctrl[g];
            assign stage_dst[g*DST_W +: DST_W]    = st_dst[g];
        end
    endgenerate

    // Occupancy tracks the valid bits the stages will hold after this edge.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (kill[k])      valid_nxt[k] = 1'b0;
            else if (load[k]) valid_nxt[k] = src_valid[k];
            else              valid_nxt[k] = st_valid[k];
        end
        occ_d = popcount(valid_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end

    assign occ = occ_q;

    // Register 0 never forwards, so a zero source matches nothing.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            fwd_a_hit[k] = st_valid[k] & st_ctrl[k][REGW_BIT] &
                           (st_dst[k] == src_a) & (src_a != '0);
            fwd_b_hit[k] = st_valid[k] & st_ctrl[k][REGW_BIT] &
                           (st_dst[k] == src_b) & (src_b != '0);
        end
        fwd_a_pri = lowest_bit(fwd_a_hit);
        fwd_b_pri = lowest_bit(fwd_b_hit);
    end

endmodule

// File: tb/tb_ctrl_pipe_stages.sv
// Bench for ctrl_pipe_stages: two instances (kill mask 111 and 011) share
// the same stimulus and are compared every cycle against an entry-level
// model of the pipeline, plus hand-computed expectations for directed cases.
module tb_ctrl_pipe_stages;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [12:0] in_ctrl;
    logic [4:0]  in_dst;
    logic [2:0]  stall, flush;
    logic        except;
    logic [4:0]  src_a, src_b;

    logic        a_rdy [2];
    logic [2:0]  a_sv  [2];
    logic [38:0] a_sc  [2];
    logic [14:0] a_sd  [2];
    logic [1:0]  a_occ [2];
    logic [2:0]  a_fah [2];
    logic [2:0]  a_fbh [2];
    logic [2:0]  a_fap [2];
    logic [2:0]  a_fbp [2];

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_pipe_stages #(.CTRL_W(13), .STAGES(3), .DST_W(5), .REGW_BIT(6),
                       .EXC_MASK(3'b111), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_dst(in_dst), .in_ready(a_rdy[0]), .stall(stall), .flush(flush),
        .except(except), .src_a(src_a), .src_b(src_b),
        .stage_valid(a_sv[0]), .stage_ctrl(a_sc[0]), .stage_dst(a_sd[0]),
        .occ(a_occ[0]), .fwd_a_hit(a_fah[0]), .fwd_b_hit(a_fbh[0]),
        .fwd_a_pri(a_fap[0]), .fwd_b_pri(a_fbp[0]));

    ctrl_pipe_stages #(.CTRL_W(13), .STAGES(3), .DST_W(5), .REGW_BIT(6),
                       .EXC_MASK(3'b011), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_dst(in_dst), .in_ready(a_rdy[1]), .stall(stall), .flush(flush),
        .except(except), .src_a(src_a), .src_b(src_b),
        .stage_valid(a_sv[1]), .stage_ctrl(a_sc[1]), .stage_dst(a_sd[1]),
        .occ(a_occ[1]), .fwd_a_hit(a_fah[1]), .fwd_b_hit(a_fbh[1]),
        .fwd_a_pri(a_fap[1]), .fwd_b_pri(a_fbp[1]));

    // Model: each stage is an entry {valid, ctrl, dst}; empty entries are all zero.
    logic        mv [2][3];
    logic [12:0] mc [2][3];
    logic [4:0]  md [2][3];

    function automatic logic [2:0] mask_of(input int u);
        return (u == 0) ? 3'b111 : 3'b011;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < 3; k++) begin
                mv[u][k] = 1'b0; mc[u][k] = '0; md[u][k] = '0;
            end
    endtask

    task automatic model_advance();
        logic        nv [3];
        logic [12:0] nc [3];
        logic [4:0]  nd [3];
        logic [2:0]  hold, kill;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            hold[k] = 1'b0;
            for (int j = k; j < 3; j++) hold[k] = hold[k] | stall[j];
        end
        for (int u = 0; u < 2; u++) begin
            kill = flush | (except ? mask_of(u) : 3'b000);
            for (int k = 0; k < 3; k++) begin
                nv[k] = 1'b0; nc[k] = '0; nd[k] = '0;
                if (kill[k]) begin
                    // cleared
                end else if (hold[k]) begin
                    nv[k] = mv[u][k]; nc[k] = mc[u][k]; nd[k] = md[u][k];
                end else if (k == 0) begin
                    if (in_valid) begin
                        nv[k] = 1'b1; nc[k] = in_ctrl; nd[k] = in_dst;
                    end
                end else if (!hold[k-1]) begin
                    nv[k] = mv[u][k-1]; nc[k] = mc[u][k-1]; nd[k] = md[u][k-1];
                end
            end
            for (int k = 0; k < 3; k++) begin
                mv[u][k] = nv[k]; mc[u][k] = nc[k]; md[u][k] = nd[k];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input logic v, input logic [12:0] c, input logic [4:0] d);
        in_valid = v; in_ctrl = c; in_dst = d;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0);
        stall = '0; flush = '0; except = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int u = 0; u < 2; u++) begin
                logic [2:0]  ev, eha, ehb, epa, epb;
                logic [38:0] ec;
                logic [14:0] ed;
                int          cnt;
                cnt = 0;
                epa = '0; epb = '0;
                for (int k = 0; k < 3; k++) begin
                    ev[k] = mv[u][k];
                    ec[k*13 +: 13] = mc[u][k];
                    ed[k*5 +: 5] = md[u][k];
                    cnt += mv[u][k] ? 1 : 0;
                    eha[k] = mv[u][k] && mc[u][k][6] && md[u][k] == src_a && src_a != 0;
                    ehb[k] = mv[u][k] && mc[u][k][6] && md[u][k] == src_b && src_b != 0;
                end
                for (int k = 2; k >= 0; k--) begin
                    if (eha[k]) epa = 3'(1 << k);
                    if (ehb[k]) epb = 3'(1 << k);
                end
                check($sformatf("u%0d in_ready", u), 64'(a_rdy[u]), 64'(stall == 0));
                check($sformatf("u%0d stage_valid", u), 64'(a_sv[u]), 64'(ev));
                check($sformatf("u%0d stage_ctrl", u), 64'(a_sc[u]), 64'(ec));
                check($sformatf("u%0d stage_dst", u), 64'(a_sd[u]), 64'(ed));
                check($sformatf("u%0d occ", u), 64'(a_occ[u]), 64'(cnt));
                check($sformatf("u%0d fwd_a_hit", u), 64'(a_fah[u]), 64'(eha));
                check($sformatf("u%0d fwd_b_hit", u), 64'(a_fbh[u]), 64'(ehb));
                check($sformatf("u%0d fwd_a_pri", u), 64'(a_fap[u]), 64'(epa));
                check($sformatf("u%0d fwd_b_pri", u), 64'(a_fbp[u]), 64'(epb));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        src_a = '0; src_b = '0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        check("reset valid no edge", 64'(a_sv[0]), 64'(0));
        check("reset occ no edge", 64'(a_occ[0]), 64'(0));
        check("reset ctrl no edge", 64'(a_sc[0]), 64'(0));
        step();
        step();
        rst = 1'b1;
        cmp_en = 1'b1;

        // Single inject walks through the stages.
        drive(1'b1, 13'h0060, 5'd8);
        step();
        drive(1'b0, '0, '0);
        check("inj valid e1", 64'(a_sv[0]), 64'(3'b001));
        check("inj occ e1", 64'(a_occ[0]), 64'(1));
        check("inj ctrl s0", 64'(a_sc[0][12:0]), 64'(13'h0060));
        step();
        check("inj valid e2", 64'(a_sv[0]), 64'(3'b010));
        check("inj ctrl s1", 64'(a_sc[0][25:13]), 64'(13'h0060));
        step();
        check("inj valid e3", 64'(a_sv[0]), 64'(3'b100));
        check("inj occ e3", 64'(a_occ[0]), 64'(1));
        check("inj ctrl s2", 64'(a_sc[0][38:26]), 64'(13'h0060));
        check("inj dst s2", 64'(a_sd[0][14:10]), 64'(8));
        step();
        check("inj valid e4", 64'(a_sv[0]), 64'(3'b000));
        check("inj occ e4", 64'(a_occ[0]), 64'(0));

        // Stream A,B,C with stage-1 stall for two cycles.
        drive(1'b1, 13'h0041, 5'd1); step();
        drive(1'b1, 13'h0042, 5'd2); step();
        drive(1'b1, 13'h0044, 5'd3); stall = 3'b010;
        #1 check("stall in_ready", 64'(a_rdy[0]), 64'(0));
        repeat (2) begin
            step();
            check("stall valid", 64'(a_sv[0]), 64'(3'b011));
            check("stall s0 B", 64'(a_sc[0][12:0]), 64'(13'h0042));
            check("stall s1 A", 64'(a_sc[0][25:13]), 64'(13'h0041));
            check("stall s2 bubble", 64'(a_sc[0][38:26]), 64'(0));
        end
        stall = '0;
        step();
        drive(1'b0, '0, '0);
        check("resume valid", 64'(a_sv[0]), 64'(3'b111));
        check("resume s2 A", 64'(a_sc[0][38:26]), 64'(13'h0041));
        step();
        check("resume s2 B", 64'(a_sc[0][38:26]), 64'(13'h0042));
        step();
        check("resume s2 C", 64'(a_sc[0][38:26]), 64'(13'h0044));
        check("resume valid end", 64'(a_sv[0]), 64'(3'b100));
        drain();

        // Stall stage 1 while flushing stage 0.
        drive(1'b1, 13'h0041, 5'd1); step();
        drive(1'b1, 13'h0042, 5'd2); step();
        check("sf occ before", 64'(a_occ[0]), 64'(2));
        drive(1'b0, '0, '0); stall = 3'b010; flush = 3'b001;
        step();
        check("sf valid", 64'(a_sv[0]), 64'(3'b010));
        check("sf occ after", 64'(a_occ[0]), 64'(1));
        check("sf s1 kept", 64'(a_sc[0][25:13]), 64'(13'h0041));
        drain();

        // Exception with full and partial kill masks.
        drive(1'b1, 13'h0041, 5'd1); step();
        drive(1'b1, 13'h0042, 5'd2); step();
        drive(1'b1, 13'h0044, 5'd3); step();
        check("exc full before", 64'(a_occ[0]), 64'(3));
        drive(1'b0, '0, '0); except = 1'b1;
        step();
        except = 1'b0;
        check("exc m111 valid", 64'(a_sv[0]), 64'(3'b000));
        check("exc m111 occ", 64'(a_occ[0]), 64'(0));
        check("exc m011 valid", 64'(a_sv[1]), 64'(3'b100));
        check("exc m011 occ", 64'(a_occ[1]), 64'(1));
        check("exc m011 s2", 64'(a_sc[1][38:26]), 64'(13'h0042));
        drain();

        // Forwarding: Z(dst0) in stage 2, X and Y (dst8) in stages 1 and 0.
        drive(1'b1, 13'h0040, 5'd0); step();
        drive(1'b1, 13'h0040, 5'd8); step();
        drive(1'b1, 13'h0040, 5'd8); step();
        drive(1'b0, '0, '0); stall = 3'b100; src_a = 5'd8; src_b = 5'd0;
        #1;
        check("fwd a hit", 64'(a_fah[0]), 64'(3'b011));
        check("fwd a pri", 64'(a_fap[0]), 64'(3'b001));
        check("fwd b zero", 64'(a_fbh[0]), 64'(3'b000));
        step();
        drain();
        drive(1'b1, 13'h0040, 5'd8); step();
        drive(1'b1, 13'h0001, 5'd8); step();
        drive(1'b0, '0, '0); stall = 3'b100;
        #1;
        check("fwd a hit nowr", 64'(a_fah[0]), 64'(3'b010));
        check("fwd a pri nowr", 64'(a_fap[0]), 64'(3'b010));
        step();
        drain();

        // Asynchronous reset in the middle of a stream.
        drive(1'b1, 13'h0041, 5'd1); step();
        drive(1'b1, 13'h0042, 5'd2); step();
        drive(1'b0, '0, '0); src_a = 5'd2;
        #1 check("pre-rst fwd", 64'(a_fah[0]), 64'(3'b001));
        #1 rst = 1'b0;
        model_reset();
        #1;
        check("rst valid", 64'(a_sv[0]), 64'(0));
        check("rst ctrl", 64'(a_sc[0]), 64'(0));
        check("rst dst", 64'(a_sd[0]), 64'(0));
        check("rst occ", 64'(a_occ[0]), 64'(0));
        check("rst fwd", 64'(a_fah[0]), 64'(0));
        step();
        rst = 1'b1;
        step();
        check("post-rst ready", 64'(a_rdy[0]), 64'(1));
        check("post-rst occ", 64'(a_occ[0]), 64'(0));

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 13'($urandom), 5'($urandom_range(0, 3)));
            for (int k = 0; k < 3; k++) begin
                stall[k] = ($urandom_range(0, 5) == 0);
                flush[k] = ($urandom_range(0, 9) == 0);
            end
            except = ($urandom_range(0, 15) == 0);
            src_a = 5'($urandom_range(0, 3));
            src_b = 5'($urandom_range(0, 3));
            step();
        end
        idle();
        step();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
